bin_to_bcd: RTL and testbench
=============================

// Module: bin_to_bcd
// PURPOSE
//   Unsigned binary to packed-BCD converter with a registered output.
//   Converts an N-bit binary value into DIGITS decimal digits, 4 bits per digit.
//   The conversion uses the shift-add-3 (double-dabble) algorithm, unrolled combinationally.
//   Used as a display/readout helper wherever binary counters feed decimal outputs.
// PARAMETERS
//   N        8   width of the binary input, in bits; legal range 1..32
//   DIGITS   (localparam) ceil(log10(2**N)); number of BCD digits; equals 3 for N=8
// PORTS
//   clk       input   1          rising-edge clock
//   rst       input   1          synchronous, active-high reset
//   data_in   input   N          unsigned binary value
//   data_out  output  4*DIGITS   packed BCD; [3:0]=units, [7:4]=tens, and so on upward
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high.
//   - Reset: data_out=0 at the first rising clk edge with rst=1.
//     rst overrides any conversion in flight; no partial value appears.
//   - Conversion core is purely combinational double-dabble:
//       - Scratch register is {BCD[4*DIGITS], BIN[N]}, starting at {0, data_in}.
//       - Repeat N times: any BCD nibble >= 5 gets +3, then shift the whole register left 1.
//       - After the N-th shift, the BCD field is the result.
//     No +3 step after the final shift.
//   - The core result is registered into data_out on every rising clk edge with rst=0.
//   - Latency is 1 clk from data_in to data_out; throughput is one conversion per clk.
//     No handshake is used.
//   - Every output nibble is in the range 0..9.
//     Unused upper digits are zero; there is no leading-zero suppression.
//   - Maximum input 2**N-1 always fits in DIGITS digits, so no overflow is possible.
//   - data_in is sampled each cycle; back-to-back changes give back-to-back results.
//   - data_out is driven only by flops; no combinational path from data_in to data_out.
// CONFIGURATION
//   BIN2BCD_IN_REG_EN
//     - Defined: data_in is first registered (reset value 0), then converted and registered.
//       Latency becomes 2 clk.
//       Reset clears both stages; data_out=0 for 2 edges after reset release with data_in=0.
//     - Undefined (default): single output register, latency 1 clk.
// TESTING
//   (N=8, macro undefined; every check is one clk after data_in is applied)
//   - rst=1 for 2 clk with data_in=8'd200 -> data_out=12'h000.
//     After rst falls, one edge later -> 12'h200.
//   - Sweep data_in 0..255, one value per clk -> data_out equals the BCD of the previous cycle's data_in.
//     Spot checks: 9->12'h009, 10->12'h010, 99->12'h099, 100->12'h100, 255->12'h255.
//   - Digit-boundary inputs 49, 50, 199 -> 12'h049, 12'h050, 12'h199.
//     Every nibble must be <= 9 for all 256 values.
//   - Assert rst while data_in toggles 37->128 -> data_out=0 on that edge.
//     Conversion resumes the cycle after rst deasserts.
//   - Parameter check N=10, input 1023 -> 16'h1023 with DIGITS=4.
//     N=4, input 15 -> 8'h15 with DIGITS=2.
//   - With BIN2BCD_IN_REG_EN defined: input 42 -> 12'h042 exactly 2 clk later.
//     Nothing changes at 1 clk.

Source files
------------

// File: rtl/bin_to_bcd_if.sv
// Binary-in / packed-BCD-out bus for bin_to_bcd. The digit count follows from N.
// There is no handshake: data_in is sampled on every clock, and data_out updates on every clock.
interface bin_to_bcd_if #(
  parameter int N = 8
);
  function automatic int calc_digits(input int n);
    longint unsigned v;
    int d;
    v = (64'd1 << n) - 64'd1;
    d = 0;
    do begin
      d++;
      v = v / 64'd10;
    end while (v != 64'd0);
    return d;
  endfunction

  localparam int DIGITS = calc_digits(N);

  logic [N-1:0]        data_in;
  logic [4*DIGITS-1:0] data_out;

  modport master (output data_in, input data_out);
  modport slave  (input data_in, output data_out);
endinterface

// File: rtl/bin_to_bcd.sv
// Unsigned binary to packed-BCD converter: a combinational double-dabble core followed by an output register.
// Optional feature: define BIN2BCD_IN_REG_EN to also register data_in. This raises the latency to 2 clk.
module bin_to_bcd #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  bin_to_bcd_if.slave  bus
);
  function automatic int calc_digits(input int n);
    longint unsigned v;
    int d;
    v = (64'd1 << n) - 64'd1;
    d = 0;
    do begin
      d++;
      v = v / 64'd10;
    end while (v != 64'd0);
    return d;
  endfunction

  localparam int DIGITS = calc_digits(N);
  localparam int W      = 4 * DIGITS + N;

  logic [N-1:0]        conv_in;
  logic [W-1:0]        scratch;
  logic [4*DIGITS-1:0] data_out_d;
  logic [4*DIGITS-1:0] data_out_q;

`ifdef BIN2BCD_IN_REG_EN
  logic [N-1:0] in_d;
  logic [N-1:0] in_q;

  always_comb begin
    in_d = bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) in_q <= '0;
    else     in_q <= in_d;
  end

  assign conv_in = in_q;
`else
  assign conv_in = bus.data_in;
`endif

  // Each iteration adjusts every nibble and then shifts. Because of this order, the final shift has no +3 after it.
  always_comb begin
    scratch = {{(4*DIGITS){1'b0}}, conv_in};
    for (int i = 0; i < N; i++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (scratch[N+4*d +: 4] >= 4'd5)
          scratch[N+4*d +: 4] = scratch[N+4*d +: 4] + 4'd3;
      end
      scratch = scratch << 1;
    end
    data_out_d = scratch[W-1:N];
  end

  always_ff @(posedge clk) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed bench for bin_to_bcd. The main instance has N=8. Two extra instances cover N=10 and N=4.
module tb_bin_to_bcd;
`ifdef BIN2BCD_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   errors;
  logic [11:0] exp_q[$];

  bin_to_bcd_if #(.N(8))  bus8  ();
  bin_to_bcd_if #(.N(10)) bus10 ();
  bin_to_bcd_if #(.N(4))  bus4  ();

  bin_to_bcd #(.N(8))  dut   (.clk(clk), .rst(rst), .bus(bus8.slave));
  bin_to_bcd #(.N(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10.slave));
  bin_to_bcd #(.N(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] bcd3(input int v);
    logic [11:0] r;
    r = '0;
    for (int d = 0; d < 3; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic wait_out(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus8.data_in = 8'd200;
    for (int k = 0; k < 2; k++) begin
      wait_out(1);
      vectors++;
      if (bus8.data_out !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want 000", k, bus8.data_out);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    wait_out(LAT);
    vectors++;
    if (bus8.data_out !== 12'h200) begin
      errors++;
      $display("FAIL reset_release: got %h want 200", bus8.data_out);
    end
  endtask

  task automatic test_spot();
    int          ins [8] = '{9, 10, 99, 100, 255, 49, 50, 199};
    logic [11:0] outs[8] = '{12'h009, 12'h010, 12'h099, 12'h100, 12'h255,
                             12'h049, 12'h050, 12'h199};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus8.data_in = 8'(ins[i]);
      wait_out(LAT);
      vectors++;
      if (bus8.data_out !== outs[i]) begin
        errors++;
        $display("FAIL spot_%0d: got %h want %h", ins[i], bus8.data_out, outs[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [11:0] exp;
    exp_q.delete();
    for (int c = 0; c < 256 + LAT - 1; c++) begin
      @(negedge clk);
      bus8.data_in = (c < 256) ? 8'(c) : 8'd255;
      if (c < 256) exp_q.push_back(bcd3(c));
      @(posedge clk);
      #1;
      if (exp_q.size() >= LAT) begin
        exp = exp_q.pop_front();
        vectors++;
        if (bus8.data_out !== exp) begin
          errors++;
          $display("FAIL sweep: got %h want %h", bus8.data_out, exp);
        end
        for (int d = 0; d < 3; d++) begin
          vectors++;
          if (bus8.data_out[4*d +: 4] > 4'd9) begin
            errors++;
            $display("FAIL sweep_nibble%0d: got %h want <=9", d, bus8.data_out[4*d +: 4]);
          end
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int ins[6] = '{0, 255, 100, 99, 1, 128};
    logic [11:0] exp;
    exp_q.delete();
    for (int c = 0; c < 6 + LAT - 1; c++) begin
      @(negedge clk);
      if (c < 6) begin
        bus8.data_in = 8'(ins[c]);
        exp_q.push_back(bcd3(ins[c]));
      end
      @(posedge clk);
      #1;
      if (exp_q.size() >= LAT) begin
        exp = exp_q.pop_front();
        vectors++;
        if (bus8.data_out !== exp) begin
          errors++;
          $display("FAIL back_to_back: got %h want %h", bus8.data_out, exp);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    bus8.data_in = 8'd37;
    wait_out(LAT);
    vectors++;
    if (bus8.data_out !== 12'h037) begin
      errors++;
      $display("FAIL mid_pre: got %h want 037", bus8.data_out);
    end
    @(negedge clk);
    rst = 1'b1;
    bus8.data_in = 8'd128;
    wait_out(1);
    vectors++;
    if (bus8.data_out !== 12'h000) begin
      errors++;
      $display("FAIL mid_rst: got %h want 000", bus8.data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_out(LAT);
    vectors++;
    if (bus8.data_out !== 12'h128) begin
      errors++;
      $display("FAIL mid_resume: got %h want 128", bus8.data_out);
    end
  endtask

  task automatic test_params();
    @(negedge clk);
    bus10.data_in = 10'd1023;
    bus4.data_in  = 4'd15;
    wait_out(LAT);
    vectors++;
    if (bus10.data_out !== 16'h1023) begin
      errors++;
      $display("FAIL n10_1023: got %h want 1023", bus10.data_out);
    end
    vectors++;
    if (bus4.data_out !== 8'h15) begin
      errors++;
      $display("FAIL n4_15: got %h want 15", bus4.data_out);
    end
    @(negedge clk);
    bus10.data_in = 10'd509;
    bus4.data_in  = 4'd9;
    wait_out(LAT);
    vectors++;
    if (bus10.data_out !== 16'h0509) begin
      errors++;
      $display("FAIL n10_509: got %h want 0509", bus10.data_out);
    end
    vectors++;
    if (bus4.data_out !== 8'h09) begin
      errors++;
      $display("FAIL n4_9: got %h want 09", bus4.data_out);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus8.data_in = 8'd0;
    wait_out(LAT);
    @(negedge clk);
    bus8.data_in = 8'd42;
    wait_out(1);
`ifdef BIN2BCD_IN_REG_EN
    vectors++;
    if (bus8.data_out !== 12'h000) begin
      errors++;
      $display("FAIL lat_1clk: got %h want 000", bus8.data_out);
    end
    wait_out(1);
`endif
    vectors++;
    if (bus8.data_out !== 12'h042) begin
      errors++;
      $display("FAIL lat_full: got %h want 042", bus8.data_out);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    bus8.data_in  = '0;
    bus10.data_in = '0;
    bus4.data_in  = '0;
    test_reset();
    test_spot();
    test_sweep();
    test_back_to_back();
    test_reset_midstream();
    test_params();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
